seq_ctrl: RTL and testbench

- Programmable step sequencer. Plays a table of up to N_STEP entries; each entry is an output value plus a per-step duration.
- Successor to the fixed free-running pattern sequencer. Adds start/stop control, one-shot or loop mode, a runtime step count, a hold (pause) input, and busy/done status.
- Sits between a register block (which supplies PTN and control) and the downstream strobe/enable logic driven by SEQ.

---
 rtl/seq_ctrl_pkg.sv | 22 ++
 rtl/seq_timer.sv | 33 +++
 rtl/seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the step sequencer: default widths, FSM state
// encoding and the step-table field offset helper.
package seq_ctrl_pkg;

    localparam int unsigned BW_SEQ_DEF     = 4;
    localparam int unsigned N_STEP_DEF     = 8;
    localparam int unsigned BW_STEP_DEF    = 3;
    localparam int unsigned BW_TIMEOUT_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit offset of entry k; the entry's duration sits at the offset and its value directly above.
    function automatic int unsigned entry_ofs(input int unsigned bw_seq,
                                              input int unsigned bw_timeout,
                                              input int unsigned k);
        return (bw_seq + bw_timeout) * k;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Step duration down counter.
//   CLK, RST : clock, asynchronous active-high reset (count clears to 0)
//   LOAD/VAL : load VAL into the counter (wins over EN)
//   EN       : decrement while the count is non-zero
//   CNT0     : count is zero
module seq_timer
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned BW_TIMEOUT = BW_TIMEOUT_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic [BW_TIMEOUT-1:0] VAL,
    input  logic                  EN,
    output logic                  CNT0
);

    logic [BW_TIMEOUT-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (LOAD) begin
            cnt_q <= VAL;
        end else if (EN && (cnt_q != '0)) begin
            cnt_q <= cnt_q - BW_TIMEOUT'(1);
        end
    end

    assign CNT0 = (cnt_q == '0);

endmodule

// File: rtl/seq_ctrl.sv
// Programmable step sequencer: plays entries 0..LAST_STEP of PTN, each
// entry holding its value on SEQ for T_k+1 unheld cycles, once or looped.
//   CLK, RST   : clock, asynchronous active-high reset
//   START/STOP : start (restart from step 0) and abort pulses; STOP wins
//   HOLD       : freezes the step timer and outputs while high
//   LOOP       : loop (1) or one-shot (0), latched on an accepted START
//   LAST_STEP  : final step index, latched (clamped to N_STEP-1) on START
//   PTN        : step table, entry k = {V_k, T_k}
//   SEQ, STEP  : current step value and index (registered)
//   BUSY, DONE : running flag; one-cycle pulse at one-shot completion
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned       BW_SEQ     = BW_SEQ_DEF,
    parameter int unsigned       N_STEP     = N_STEP_DEF,
    parameter int unsigned       BW_STEP    = BW_STEP_DEF,
    parameter int unsigned       BW_TIMEOUT = BW_TIMEOUT_DEF,
    parameter logic [BW_SEQ-1:0] RV         = {BW_SEQ{1'b0}}
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     START,
    input  logic                                     STOP,
    input  logic                                     HOLD,
    input  logic                                     LOOP,
    input  logic [BW_STEP-1:0]                       LAST_STEP,
    input  logic [(BW_SEQ+BW_TIMEOUT)*N_STEP-1:0]    PTN,
    output logic [BW_SEQ-1:0]                        SEQ,
    output logic [BW_STEP-1:0]                       STEP,
    output logic                                     BUSY,
    output logic                                     DONE
);

    localparam int unsigned        N_TBL    = 2 ** BW_STEP;
    localparam logic [BW_STEP-1:0] LAST_MAX = BW_STEP'(N_STEP - 1);

    // Table unpacked to one entry per index value; unused indices read as zero.
    logic [BW_SEQ-1:0]     tbl_v [N_TBL];
    logic [BW_TIMEOUT-1:0] tbl_t [N_TBL];

    for (genvar k = 0; k < N_TBL; k++) begin : g_tbl
        if (k < N_STEP) begin : g_ent
            assign tbl_t[k] = PTN[entry_ofs(BW_SEQ, BW_TIMEOUT, k) +: BW_TIMEOUT];
            assign tbl_v[k] = PTN[entry_ofs(BW_SEQ, BW_TIMEOUT, k) + BW_TIMEOUT +: BW_SEQ];
        end else begin : g_pad
            assign tbl_t[k] = '0;
            assign tbl_v[k] = '0;
        end
    end

    state_t              state_q,  state_nxt;
    logic [BW_SEQ-1:0]   seq_q,    seq_nxt;
    logic [BW_STEP-1:0]  step_q,   step_nxt;
    logic                busy_q,   busy_nxt;
    logic                done_q,   done_nxt;
    logic                loop_q,   loop_nxt;
    logic [BW_STEP-1:0]  last_q,   last_nxt;

    logic                  tmr_load;
    logic [BW_TIMEOUT-1:0] tmr_val;
    logic                  tmr_en;
    logic                  tmr_zero;

    logic [BW_STEP-1:0] step_inc;
    logic [BW_STEP-1:0] last_clamp;

    assign step_inc   = step_q + BW_STEP'(1);
    assign last_clamp = (LAST_STEP > LAST_MAX) ? LAST_MAX : LAST_STEP;

    seq_timer #(
        .BW_TIMEOUT (BW_TIMEOUT)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (tmr_load),
        .VAL  (tmr_val),
        .EN   (tmr_en),
        .CNT0 (tmr_zero)
    );

    // Next-state and next-output logic; priority STOP > START > HOLD > timer.
    always_comb begin
        state_nxt = state_q;
        seq_nxt   = seq_q;
        step_nxt  = step_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        loop_nxt  = loop_q;
        last_nxt  = last_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;

        if (STOP) begin
            state_nxt = ST_IDLE;
            seq_nxt   = RV;
            step_nxt  = '0;
            busy_nxt  = 1'b0;
            tmr_load  = 1'b1;
        end else if (START) begin
            state_nxt = ST_RUN;
            seq_nxt   = tbl_v[0];
            step_nxt  = '0;
            busy_nxt  = 1'b1;
            loop_nxt  = LOOP;
            last_nxt  = last_clamp;
            tmr_load  = 1'b1;
            tmr_val   = tbl_t[0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (HOLD) begin
                    end else if (!tmr_zero) begin
                        tmr_en = 1'b1;
                    end else if (step_q < last_q) begin
                        seq_nxt  = tbl_v[step_inc];
                        step_nxt = step_inc;
                        tmr_load = 1'b1;
                        tmr_val  = tbl_t[step_inc];
                    end else if (loop_q) begin
                        // Wrap to entry 0; SEQ reloads V_0 so a single-step loop holds steady.
                        seq_nxt  = tbl_v[0];
                        step_nxt = '0;
                        tmr_load = 1'b1;
                        tmr_val  = tbl_t[0];
                    end else begin
                        state_nxt = ST_IDLE;
                        seq_nxt   = RV;
                        step_nxt  = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        tmr_load  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            seq_q   <= RV;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_nxt;
            seq_q   <= seq_nxt;
            step_q  <= step_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            loop_q  <= loop_nxt;
            last_q  <= last_nxt;
        end
    end

    assign SEQ  = seq_q;
    assign STEP = step_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed scenarios plus randomized stimulus, all
// checked cycle by cycle against a step/remaining-cycles reference model.
module tb_seq_ctrl;

    localparam int unsigned BW_SEQ     = 4;
    localparam int unsigned N_STEP     = 8;
    localparam int unsigned BW_STEP    = 4;
    localparam int unsigned BW_TIMEOUT = 4;
    localparam int unsigned BW_PTN     = (BW_SEQ + BW_TIMEOUT) * N_STEP;
    localparam logic [BW_SEQ-1:0] RV   = 4'h0;

    logic                CLK;
    logic                RST;
    logic                START;
    logic                STOP;
    logic                HOLD;
    logic                LOOP;
    logic [BW_STEP-1:0]  LAST_STEP;
    logic [BW_PTN-1:0]   PTN;
    logic [BW_SEQ-1:0]   SEQ;
    logic [BW_STEP-1:0]  STEP;
    logic                BUSY;
    logic                DONE;

    int n_checks;
    int n_errors;

    // Reference model: active flag, step index, cycles remaining in the step.
    bit          m_busy;
    bit          m_done;
    bit          m_loop;
    int          m_step;
    int          m_left;
    int          m_last;
    logic [3:0]  m_val;

    logic [3:0] exp_os [7];

    seq_ctrl #(
        .BW_SEQ     (BW_SEQ),
        .N_STEP     (N_STEP),
        .BW_STEP    (BW_STEP),
        .BW_TIMEOUT (BW_TIMEOUT),
        .RV         (RV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .STOP      (STOP),
        .HOLD      (HOLD),
        .LOOP      (LOOP),
        .LAST_STEP (LAST_STEP),
        .PTN       (PTN),
        .SEQ       (SEQ),
        .STEP      (STEP),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ent_v(input int k);
        logic [BW_PTN-1:0] p;
        p = PTN;
        return p[k*8+4 +: 4];
    endfunction

    function automatic logic [3:0] ent_t(input int k);
        logic [BW_PTN-1:0] p;
        p = PTN;
        return p[k*8 +: 4];
    endfunction

    task automatic set_entry(input int k, input logic [3:0] v, input logic [3:0] t);
        PTN[k*8 +: 4]   = t;
        PTN[k*8+4 +: 4] = v;
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_loop = 0;
        m_step = 0; m_left = 0; m_last = 0;
        m_val  = RV;
    endtask

    task automatic model_enter(input int k);
        m_step = k;
        m_val  = ent_v(k);
        m_left = int'(ent_t(k)) + 1;
    endtask

    // One clock edge of the sequencer's rules, using the inputs present at the edge.
    task automatic model_edge();
        m_done = 0;
        if (STOP) begin
            m_busy = 0; m_val = RV; m_step = 0;
        end else if (START) begin
            m_busy = 1;
            m_loop = LOOP;
            m_last = (int'(LAST_STEP) > N_STEP - 1) ? N_STEP - 1 : int'(LAST_STEP);
            model_enter(0);
        end else if (m_busy && !HOLD) begin
            if (m_left > 1)           m_left--;
            else if (m_step < m_last) model_enter(m_step + 1);
            else if (m_loop)          model_enter(0);
            else begin
                m_busy = 0; m_val = RV; m_step = 0; m_done = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("seq",  32'(SEQ),  32'(m_val));
        check("step", 32'(STEP), 32'(m_step));
        check("busy", 32'(BUSY), 32'(m_busy));
        check("done", 32'(DONE), 32'(m_done));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic base_table();
        PTN = '0;
        set_entry(0, 4'hA, 4'd1);
        set_entry(1, 4'h5, 4'd0);
        set_entry(2, 4'hC, 4'd3);
        LAST_STEP = 4'd2;
    endtask

    task automatic stop_run();
        STOP = 1; tick(); STOP = 0;
    endtask

    task automatic wait_step(input int s, input string tag);
        for (int i = 0; i < 40 && int'(STEP) != s; i++) tick();
        check(tag, 32'(STEP), 32'(s));
    endtask

    initial begin
        int cnt1, cnt2, hold_left, n5;
        n_checks = 0; n_errors = 0;
        exp_os = '{4'hA, 4'hA, 4'h5, 4'hC, 4'hC, 4'hC, 4'hC};
        START = 0; STOP = 0; HOLD = 0; LOOP = 0; LAST_STEP = '0; PTN = '0;
        RST = 1;
        model_reset();
        #12;
        compare_model();
        RST = 0;

        // One-shot run
        base_table(); LOOP = 0; START = 1;
        for (int i = 0; i < 7; i++) begin
            tick(); START = 0;
            check("os_seq", 32'(SEQ), 32'(exp_os[i]));
            check("os_busy", 32'(BUSY), 32'd1);
        end
        tick();
        check("os_end_seq", 32'(SEQ), 32'(RV));
        check("os_end_busy", 32'(BUSY), 32'd0);
        check("os_end_done", 32'(DONE), 32'd1);
        tick();
        check("os_done_pulse", 32'(DONE), 32'd0);

        // Loop run: period of 7 cycles, never DONE
        LOOP = 1; START = 1;
        for (int i = 0; i < 21; i++) begin
            tick(); START = 0;
            check("loop_seq", 32'(SEQ), 32'(exp_os[i % 7]));
            check("loop_done", 32'(DONE), 32'd0);
        end
        stop_run();

        // HOLD while timer==0 in step 1 and mid-count in step 2
        LOOP = 0; START = 1; tick(); START = 0;
        cnt1 = 0; cnt2 = 0; hold_left = 0;
        for (int i = 0; i < 40; i++) begin
            if (DONE) break;
            if (BUSY && STEP == 1) cnt1++;
            if (BUSY && STEP == 2) cnt2++;
            if (STEP == 1 && cnt1 == 1) hold_left = 2;
            if (STEP == 2 && cnt2 == 2) hold_left = 3;
            HOLD = (hold_left > 0);
            if (hold_left > 0) hold_left--;
            tick();
        end
        HOLD = 0;
        check("hold_t0_len", 32'(cnt1), 32'd3);
        check("hold_len", 32'(cnt2), 32'd7);
        check("hold_done", 32'(DONE), 32'd1);
        tick();

        // STOP together with START: idle, no DONE
        LOOP = 1; START = 1; tick(); START = 0; tick();
        START = 1; STOP = 1; tick(); START = 0; STOP = 0;
        check("stopstart_busy", 32'(BUSY), 32'd0);
        check("stopstart_done", 32'(DONE), 32'd0);
        check("stopstart_seq", 32'(SEQ), 32'(RV));

        // START alone at step 1 restarts from step 0
        START = 1; tick(); START = 0;
        wait_step(1, "reach_step1");
        START = 1; tick(); START = 0;
        check("restart_seq", 32'(SEQ), 32'hA);
        check("restart_step", 32'(STEP), 32'd0);
        stop_run();

        // LAST_STEP beyond the table is clamped to step 7
        PTN = '0;
        for (int k = 0; k < 8; k++) set_entry(k, 4'(k + 3), 4'd0);
        LAST_STEP = 4'd9; LOOP = 0; START = 1; tick(); START = 0;
        for (int i = 0; i < 8; i++) begin
            check("clamp_step", 32'(STEP), 32'(i));
            tick();
        end
        check("clamp_done", 32'(DONE), 32'd1);
        tick();

        // PTN rewrite mid-step takes effect only at the next entry
        base_table(); set_entry(1, 4'h5, 4'd2); LOOP = 1;
        START = 1; tick(); START = 0;
        wait_step(1, "ptn_reach1");
        set_entry(1, 4'hF, 4'd2);
        n5 = 0;
        for (int i = 0; i < 40 && STEP == 1; i++) begin
            if (SEQ == 4'h5) n5++;
            tick();
        end
        check("ptn_hold_old", 32'(n5), 32'd3);
        wait_step(1, "ptn_reach1b");
        check("ptn_new_val", 32'(SEQ), 32'hF);
        stop_run();

        // Asynchronous reset mid-run, then replay from step 0
        base_table(); LOOP = 1; START = 1; tick(); START = 0;
        wait_step(2, "rst_reach2");
        #3; RST = 1; #1;
        check("arst_seq", 32'(SEQ), 32'(RV));
        check("arst_step", 32'(STEP), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        model_reset();
        #1; RST = 0;
        START = 1; tick(); START = 0;
        check("arst_replay_seq", 32'(SEQ), 32'hA);
        check("arst_replay_step", 32'(STEP), 32'd0);
        stop_run();

        // Randomized traffic against the model
        PTN = {$urandom, $urandom};
        for (int i = 0; i < 3000; i++) begin
            START     = ($urandom_range(0, 24) == 0);
            STOP      = ($urandom_range(0, 60) == 0);
            HOLD      = ($urandom_range(0, 4) == 0);
            LOOP      = 1'($urandom);
            LAST_STEP = 4'($urandom_range(0, 10));
            if ($urandom_range(0, 30) == 0) PTN = {$urandom, $urandom};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
